// File: rtl/illusion_raster_pkg.sv
// Shared raster definitions: default coordinate width, coordinate type and
// the AABB scanner state encoding.
package illusion_raster_pkg;

  localparam int unsigned COORD_WIDTH_DEFAULT = 11;

  typedef logic [COORD_WIDTH_DEFAULT-1:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/aabb_scanner.sv
// Axis-aligned bounding-box scanner: accepts one box (inclusive min/max
// corners), then streams every pixel inside it in row-major order with a
// valid/ready handshake. Degenerate boxes produce a one-cycle empty pulse.
module aabb_scanner
  import illusion_raster_pkg::*;
#(
  parameter int unsigned COORD_WIDTH = COORD_WIDTH_DEFAULT
) (
  input  logic                        aClock,
  input  logic                        aReset,
  input  logic [1:0][COORD_WIDTH-1:0] aMin,
  input  logic [1:0][COORD_WIDTH-1:0] aMax,
  input  logic                        aValid,
  output logic                        anOutReady,
  output logic [1:0][COORD_WIDTH-1:0] anOutPixel,
  output logic                        anOutValid,
  input  logic                        aReady,
  output logic                        anOutLast,
  output logic                        anOutEmpty
);

  scan_state_t                 state;
  logic [1:0][COORD_WIDTH-1:0] box_min;
  logic [1:0][COORD_WIDTH-1:0] box_max;
  logic [1:0][COORD_WIDTH-1:0] pixel;
  logic                        empty;
  logic                        row_end;
  logic                        box_end;

  // End detection compares against the latched max so a max of all-ones
  // terminates without relying on counter overflow.
  always_comb begin
    row_end    = (pixel[0] == box_max[0]);
    box_end    = row_end && (pixel[1] == box_max[1]);
    anOutReady = (state == IDLE);
    anOutValid = (state == SCAN);
    anOutLast  = (state == SCAN) && box_end;
    anOutPixel = pixel;
    anOutEmpty = empty;
  end

  // Box acceptance, degenerate detection and row-major pixel stepping.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      state   <= IDLE;
      box_min <= '0;
      box_max <= '0;
      pixel   <= '0;
      empty   <= 1'b0;
    end else begin
      empty <= 1'b0;
      case (state)
        IDLE: begin
          if (aValid) begin
            box_min <= aMin;
            box_max <= aMax;
            if ((aMin[0] > aMax[0]) || (aMin[1] > aMax[1])) begin
              empty <= 1'b1;
            end else begin
              pixel <= aMin;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (aReady) begin
            if (box_end) begin
              state <= IDLE;
            end else if (row_end) begin
              pixel[0] <= box_min[0];
              pixel[1] <= pixel[1] + COORD_WIDTH'(1);
            end else begin
              pixel[0] <= pixel[0] + COORD_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
